// File: rtl/std_seq_divmod.sv
// Multi-cycle radix-2 restoring unsigned divider with go/done handshake.
// Optional div_by_zero flag is built only when STD_SEQ_DIVMOD_DIVZ_EN is defined.
module std_seq_divmod #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             done
`ifdef STD_SEQ_DIVMOD_DIVZ_EN
   ,
   output logic             div_by_zero
`endif
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic [WIDTH-1:0] quo_next;
   logic [CW-1:0]    count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a value held (which would infer a latch).
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (count == LAST) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One restoring step: shift the next dividend bit into the partial
   // remainder and keep the difference when the divisor fits. A bit shifted
   // out of the top of rem means the value certainly exceeds the divisor.
   always_comb begin
      shifted  = {rem[WIDTH-1:0], dividend[WIDTH-1]};
      trial    = shifted - {1'b0, divisor};
      q_bit    = rem[WIDTH] | (shifted >= {1'b0, divisor});
      rem_next = q_bit ? trial : shifted;
      quo_next = {dividend[WIDTH-2:0], q_bit};
   end

   // The dividend register doubles as the quotient: each step shifts one
   // dividend bit out of the top and one quotient bit in at the bottom.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dividend      <= '0;
         divisor       <= '0;
         rem           <= '0;
         count         <= '0;
         out_quotient  <= '0;
         out_remainder <= '0;
         done          <= 1'b0;
      end else begin
         done <= last;
         if (accept) begin
            dividend <= left;
            divisor  <= right;
            rem      <= '0;
            count    <= '0;
         end else if (state == BUSY) begin
            dividend <= quo_next;
            rem      <= rem_next;
            count    <= count + CW'(1);
            if (last) begin
               out_quotient  <= quo_next;
               out_remainder <= rem_next[WIDTH-1:0];
            end
         end
      end
   end

`ifdef STD_SEQ_DIVMOD_DIVZ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_by_zero <= 1'b0;
      end else if (accept) begin
         div_by_zero <= (right == '0);
      end
   end
`endif

endmodule

// File: tb/tb_std_seq_divmod.sv
// Self-checking bench for std_seq_divmod: a 32-bit and a 4-bit instance
// checked against plain-arithmetic division (STD_SEQ_DIVMOD_DIVZ_EN aware).
module tb_std_seq_divmod;

   localparam int W  = 32;
   localparam int W4 = 4;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          go    = 1'b0;
   logic [W-1:0]  left  = '0;
   logic [W-1:0]  right = '0;
   logic [W-1:0]  quot;
   logic [W-1:0]  remd;
   logic          done;
   logic          go4    = 1'b0;
   logic [W4-1:0] left4  = '0;
   logic [W4-1:0] right4 = '0;
   logic [W4-1:0] quot4;
   logic [W4-1:0] remd4;
   logic          done4;
`ifdef STD_SEQ_DIVMOD_DIVZ_EN
   logic          dz;
   logic          dz4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   std_seq_divmod #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .go           (go),
      .left         (left),
      .right        (right),
      .out_quotient (quot),
      .out_remainder(remd),
      .done         (done)
`ifdef STD_SEQ_DIVMOD_DIVZ_EN
      ,
      .div_by_zero  (dz)
`endif
   );

   std_seq_divmod #(.WIDTH(W4)) dut4 (
      .clk          (clk),
      .reset        (reset),
      .go           (go4),
      .left         (left4),
      .right        (right4),
      .out_quotient (quot4),
      .out_remainder(remd4),
      .done         (done4)
`ifdef STD_SEQ_DIVMOD_DIVZ_EN
      ,
      .div_by_zero  (dz4)
`endif
   );

   // Reference: ordinary unsigned division; divide by zero gives all ones / dividend.
   function automatic logic [31:0] model_q(input logic [31:0] l, input logic [31:0] r);
      if (r == 32'd0) return 32'hFFFF_FFFF;
      return l / r;
   endfunction

   function automatic logic [31:0] model_r(input logic [31:0] l, input logic [31:0] r);
      if (r == 32'd0) return l;
      return l % r;
   endfunction

   // Starts just after a clock edge with the 32-bit DUT idle; ends the same way.
   task automatic run32(input logic [31:0] l, input logic [31:0] r,
                        output logic [31:0] q_o, output logic [31:0] r_o, output int lat);
      go = 1'b1; left = l; right = r;
      @(posedge clk); #1;
      go = 1'b0; left = $urandom; right = $urandom;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      q_o = quot;
      r_o = remd;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width32 done=%b required 0", done);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] l, input logic [31:0] r);
      logic [31:0] q_o, r_o;
      int lat;
      run32(l, r, q_o, r_o, lat);
      checks++;
      if (lat !== W) begin
         errors++;
         $display("FAIL %s latency got %0d required %0d", name, lat, W);
      end
      checks++;
      if (q_o !== model_q(l, r)) begin
         errors++;
         $display("FAIL %s quotient got %h required %h", name, q_o, model_q(l, r));
      end
      checks++;
      if (r_o !== model_r(l, r)) begin
         errors++;
         $display("FAIL %s remainder got %h required %h", name, r_o, model_r(l, r));
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (quot !== '0 || remd !== '0) begin
         errors++;
         $display("FAIL reset_results got q=%h r=%h required 0", quot, remd);
      end
      checks++;
      if (done !== 1'b0 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_done got %b/%b required 0", done, done4);
      end
      checks++;
      if (quot4 !== '0 || remd4 !== '0) begin
         errors++;
         $display("FAIL reset_results4 got q=%h r=%h required 0", quot4, remd4);
      end
`ifdef STD_SEQ_DIVMOD_DIVZ_EN
      checks++;
      if (dz !== 1'b0 || dz4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_dz got %b/%b required 0", dz, dz4);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      check32("div_100_7", 32'd100, 32'd7);
   endtask

   task automatic test_boundaries;
      check32("div_max_1", 32'hFFFF_FFFF, 32'd1);
      check32("div_5_9", 32'd5, 32'd9);
      check32("div_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   task automatic test_div_zero;
      check32("div_1234_0", 32'd1234, 32'd0);
`ifdef STD_SEQ_DIVMOD_DIVZ_EN
      checks++;
      if (dz !== 1'b1) begin
         errors++;
         $display("FAIL dz_set got %b required 1", dz);
      end
`endif
      check32("div_10_3", 32'd10, 32'd3);
`ifdef STD_SEQ_DIVMOD_DIVZ_EN
      checks++;
      if (dz !== 1'b0) begin
         errors++;
         $display("FAIL dz_clear got %b required 0", dz);
      end
`endif
   endtask

   task automatic test_random;
      for (int n = 0; n < 24; n++) begin
         logic [31:0] l, r;
         l = $urandom;
         r = $urandom >> $urandom_range(31, 0);
         check32("random32", l, r);
      end
   endtask

   // go held high: acceptance k happens at edge 34*k, its done 32 edges later.
   task automatic test_back_to_back;
      logic [31:0] ol [0:199];
      logic [31:0] orr[0:199];
      int next_done = W;
      int seen = 0;
      for (int cyc = 0; cyc < 200 && seen < 4; cyc++) begin
         left  = $urandom;
         right = $urandom >> $urandom_range(28, 0);
         go    = 1'b1;
         ol[cyc]  = left;
         orr[cyc] = right;
         @(posedge clk); #1;
         if (done) begin
            int idx;
            idx = (cyc >= W) ? cyc - W : 0;
            checks++;
            if (cyc != next_done) begin
               errors++;
               $display("FAIL b2b_done_edge got %0d required %0d", cyc, next_done);
            end
            checks++;
            if (quot !== model_q(ol[idx], orr[idx])) begin
               errors++;
               $display("FAIL b2b_quotient got %h required %h", quot, model_q(ol[idx], orr[idx]));
            end
            checks++;
            if (remd !== model_r(ol[idx], orr[idx])) begin
               errors++;
               $display("FAIL b2b_remainder got %h required %h", remd, model_r(ol[idx], orr[idx]));
            end
            next_done = cyc + W + 2;
            seen++;
            if (seen == 4) go = 1'b0;
         end
      end
      go = 1'b0;
      checks++;
      if (seen != 4) begin
         errors++;
         $display("FAIL b2b_count got %0d required 4", seen);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int pulses = 0;
      check32("prime_100_7", 32'd100, 32'd7);
      go = 1'b1; left = 32'd100; right = 32'd7;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (quot !== '0 || remd !== '0) begin
         errors++;
         $display("FAIL midreset_results got q=%h r=%h required 0", quot, remd);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL midreset_done got %b required 0", done);
      end
`ifdef STD_SEQ_DIVMOD_DIVZ_EN
      checks++;
      if (dz !== 1'b0) begin
         errors++;
         $display("FAIL midreset_dz got %b required 0", dz);
      end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midreset_no_done got %0d pulses required 0", pulses);
      end
      check32("after_reset_81_9", 32'd81, 32'd9);
   endtask

   task automatic test_width4_sweep;
      int order[256];
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int k = 0; k < 256; k++) begin
         logic [3:0] l, r, eq, er;
         int lat;
         l  = 4'(order[k] >> 4);
         r  = 4'(order[k]);
         eq = 4'(model_q({28'd0, l}, {28'd0, r}));
         er = 4'(model_r({28'd0, l}, {28'd0, r}));
         go4 = 1'b1; left4 = l; right4 = r;
         @(posedge clk); #1;
         go4 = 1'b0; left4 = 4'($urandom); right4 = 4'($urandom);
         lat = -1;
         for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (done4) begin
               lat = i;
               break;
            end
         end
         checks++;
         if (lat != W4) begin
            errors++;
            $display("FAIL sweep4_latency %0d/%0d got %0d required %0d", l, r, lat, W4);
         end
         checks++;
         if (quot4 !== eq) begin
            errors++;
            $display("FAIL sweep4_quotient %0d/%0d got %0d required %0d", l, r, quot4, eq);
         end
         checks++;
         if (remd4 !== er) begin
            errors++;
            $display("FAIL sweep4_remainder %0d/%0d got %0d required %0d", l, r, remd4, er);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_boundaries;
      test_div_zero;
      test_random;
      test_back_to_back;
      test_reset_mid;
      test_width4_sweep;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
